// File: rtl/fios_res_collector.sv
// fios_res_collector: gathers the word-serial FIOS Montgomery result (LSW first),
// performs the final conditional subtraction of p on the fly with a word-serial
// borrow chain, and presents the reduced s*17-bit result on a valid/ready port.
module fios_res_collector #(
    parameter int unsigned s         = 8,
    parameter bit          FINAL_SUB = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              res_valid_i,
    input  logic [16:0]       res_i,
    input  logic [s*17-1:0]   p_i,
    output logic [s*17-1:0]   result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int unsigned W     = 17;
    localparam int unsigned RW    = s * W;
    localparam int unsigned IDX_W = (s > 1) ? $clog2(s) : 1;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_borrow;
    logic [RW-1:0]      r_raw;
    logic [RW-1:0]      r_sub;

    logic [W-1:0]       w_p_word;
    logic               w_borrow_in;
    logic [W:0]         w_diff;
    logic               w_last;
    logic               w_accept;
    logic [RW-1:0]      w_raw_next;
    logic [RW-1:0]      w_sub_next;

    // One borrow-chain step: current word minus the matching modulus word.
    always_comb begin
        w_p_word    = p_i[r_idx*W +: W];
        w_borrow_in = (r_idx == '0) ? 1'b0 : r_borrow;
        w_diff      = {1'b0, res_i} - {1'b0, w_p_word} - {{W{1'b0}}, w_borrow_in};
        w_last      = (r_idx == IDX_W'(s - 1));
        // A word is taken while collecting, or in DONE when the handshake frees the slot.
        w_accept    = res_valid_i && ((r_state == ST_COLLECT) || result_ready_i);
    end

    // Raw and subtracted images with the current word merged in.
    always_comb begin
        w_raw_next                 = r_raw;
        w_raw_next[r_idx*W +: W]   = res_i;
        w_sub_next                 = r_sub;
        w_sub_next[r_idx*W +: W]   = w_diff[W-1:0];
    end

    // Collection FSM, result register, handshake and sticky overflow flag.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state        <= ST_COLLECT;
            r_idx          <= '0;
            r_borrow       <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            if (r_state == ST_DONE) begin
                if (result_ready_i) begin
                    r_state        <= ST_COLLECT;
                    result_valid_o <= 1'b0;
                end else if (res_valid_i) begin
                    overflow_o <= 1'b1;
                end
            end
            if (w_accept) begin
                r_raw    <= w_raw_next;
                r_sub    <= w_sub_next;
                r_borrow <= w_diff[W];
                if (w_last) begin
                    r_idx          <= '0;
                    r_state        <= ST_DONE;
                    result_valid_o <= 1'b1;
                    // No final borrow means raw >= p, so the subtracted image is the answer.
                    result_o       <= (FINAL_SUB && !w_diff[W]) ? w_sub_next : w_raw_next;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    // Busy while a partial result is held.
    assign busy_o = (r_state == ST_COLLECT) && (r_idx != '0);

endmodule

// File: tb/tb_fios_res_collector.sv
// Bench for fios_res_collector: two s=2 instances (subtraction on / off) share
// stimulus; results are compared with an integer-level reference model.
module tb_fios_res_collector;

    localparam int unsigned S  = 2;
    localparam int unsigned W  = 17;
    localparam int unsigned RW = S * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          res_valid;
    logic [W-1:0]  res;
    logic [RW-1:0] p;
    logic          ready;
    logic [RW-1:0] result_fs, result_raw;
    logic          valid_fs, valid_raw;
    logic          busy_fs, busy_raw;
    logic          ovf_fs, ovf_raw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fios_res_collector #(.s(S), .FINAL_SUB(1'b1)) dut_fs (
        .clock_i(clk), .reset_i(reset), .res_valid_i(res_valid), .res_i(res),
        .p_i(p), .result_o(result_fs), .result_valid_o(valid_fs),
        .result_ready_i(ready), .busy_o(busy_fs), .overflow_o(ovf_fs)
    );

    fios_res_collector #(.s(S), .FINAL_SUB(1'b0)) dut_raw (
        .clock_i(clk), .reset_i(reset), .res_valid_i(res_valid), .res_i(res),
        .p_i(p), .result_o(result_raw), .result_valid_o(valid_raw),
        .result_ready_i(ready), .busy_o(busy_raw), .overflow_o(ovf_raw)
    );

    // Reference: one conditional subtraction on the whole integer.
    function automatic logic [RW-1:0] ref_result(input logic [RW-1:0] raw,
                                                 input logic [RW-1:0] pv,
                                                 input bit fsub);
        if (fsub && (raw >= pv)) return raw - pv;
        return raw;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        res_valid = 1'b1;
        res       = w;
        step();
        res_valid = 1'b0;
        res       = '0;
    endtask

    task automatic check_result(input string tag, input logic [RW-1:0] pv, input logic [RW-1:0] raw);
        check({tag, ".valid"},     64'(valid_fs),   64'd1);
        check({tag, ".valid_raw"}, 64'(valid_raw),  64'd1);
        check({tag, ".busy"},      64'(busy_fs),    64'd0);
        check({tag, ".res_sub"},   64'(result_fs),  64'(ref_result(raw, pv, 1'b1)));
        check({tag, ".res_raw"},   64'(result_raw), 64'(ref_result(raw, pv, 1'b0)));
    endtask

    // Full two-word result with an optional gap between the words.
    task automatic run_result(input string tag, input logic [RW-1:0] pv,
                              input logic [RW-1:0] raw, input int gap);
        p = pv;
        send_word(raw[W-1:0]);
        check({tag, ".busy_w0"},  64'(busy_fs),  64'd1);
        check({tag, ".valid_w0"}, 64'(valid_fs), 64'd0);
        for (int g = 0; g < gap; g++) begin
            step();
            check({tag, ".busy_gap"}, 64'(busy_fs), 64'd1);
        end
        send_word(raw[RW-1:W]);
        check_result(tag, pv, raw);
    endtask

    initial begin
        logic [RW-1:0] pv, raw;
        logic [63:0]   r64, two_p;
        int            mode;

        reset     = 1'b1;
        res_valid = 1'b0;
        res       = '0;
        p         = '0;
        ready     = 1'b1;
        repeat (2) step();
        check("rst.valid",  64'(valid_fs),   64'd0);
        check("rst.busy",   64'(busy_fs),    64'd0);
        check("rst.ovf",    64'(ovf_fs),     64'd0);
        check("rst.res",    64'(result_fs),  64'd0);
        check("rst.resraw", 64'(result_raw), 64'd0);
        reset = 1'b0;
        step();

        // Directed values with ready held high.
        run_result("d9",  {17'd0, 17'd7}, {17'd0, 17'd9}, 0);
        check("d9.lit", 64'(result_fs), 64'd2);
        run_result("d5",  {17'd0, 17'd7}, {17'd0, 17'd5}, 0);
        check("d5.lit", 64'(result_fs), 64'd5);
        run_result("d7",  {17'd0, 17'd7}, {17'd0, 17'd7}, 1);
        check("d7.lit", 64'(result_fs), 64'd0);
        run_result("dbr", {17'd1, 17'd1}, {17'd2, 17'd0}, 0);
        check("dbr.lit",    64'(result_fs),  64'h1FFFF);
        check("dbr.litraw", 64'(result_raw), 64'h40000);
        step();
        check("pulse.drop", 64'(valid_fs), 64'd0);

        // Randomized results, streamed back to back with random gaps.
        for (int t = 0; t < 40; t++) begin
            pv = RW'({$urandom, $urandom});
            if (pv == '0) pv = RW'(1);
            two_p = 64'(pv) * 64'd2;
            r64   = {$urandom, $urandom};
            mode  = int'($urandom_range(0, 3));
            if (mode == 0)      raw = pv;
            else if (mode == 1) raw = RW'(r64 % 64'(pv));
            else                raw = RW'(r64 % two_p);
            run_result("rnd", pv, raw, int'($urandom_range(0, 2)));
        end
        check("rnd.ovf", 64'(ovf_fs), 64'd0);

        // Backpressure: a word arriving while the result is pending is dropped.
        step();
        ready = 1'b0;
        run_result("bp", {17'd0, 17'd7}, {17'd0, 17'd9}, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                res_valid = 1'b1;
                res       = 17'h123;
            end
            step();
            res_valid = 1'b0;
            check("bp.hold_valid", 64'(valid_fs),   64'd1);
            check("bp.hold_res",   64'(result_fs),  64'd2);
            check("bp.hold_raw",   64'(result_raw), 64'd9);
        end
        check("bp.ovf",     64'(ovf_fs),  64'd1);
        check("bp.ovf_raw", 64'(ovf_raw), 64'd1);
        ready = 1'b1;
        step();
        check("bp.release", 64'(valid_fs), 64'd0);
        run_result("bp2", {17'd0, 17'd7}, {17'd0, 17'd5}, 0);
        check("bp2.ovf", 64'(ovf_fs), 64'd1);

        // Handshake collision: first word of the next result lands on the handshake edge.
        step();
        ready = 1'b0;
        run_result("col_a", {17'd0, 17'd7}, {17'd0, 17'd11}, 0);
        step();
        check("col_a.hold", 64'(valid_fs), 64'd1);
        ready = 1'b1;
        p     = {17'd1, 17'd50};
        send_word(17'd100);
        check("col.valid", 64'(valid_fs), 64'd0);
        check("col.busy",  64'(busy_fs),  64'd1);
        send_word(17'd3);
        check_result("col_b", {17'd1, 17'd50}, {17'd3, 17'd100});
        check("col_b.lit", 64'(result_fs), 64'({17'd2, 17'd50}));

        // Reset in the middle of a result discards the partial word and borrow.
        step();
        p = {17'd0, 17'd7};
        send_word(17'd0);
        check("mid.busy", 64'(busy_fs), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid.rst_busy",  64'(busy_fs),   64'd0);
        check("mid.rst_valid", 64'(valid_fs),  64'd0);
        check("mid.rst_ovf",   64'(ovf_fs),    64'd0);
        check("mid.rst_res",   64'(result_fs), 64'd0);
        run_result("post", {17'd0, 17'd7}, {17'd0, 17'd9}, 0);
        check("post.lit", 64'(result_fs), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fios_res_collector.md
# fios_res_collector

Downstream stage of the FIOS Montgomery multiplier. It captures the word-serial 17-bit result stream, least significant word first, and performs the final conditional subtraction (result − p when result ≥ p) on the fly with a word-serial borrow chain. It presents the full s×17-bit reduced result on a valid/ready interface. The multiplier cannot stall, so the word input has no backpressure; overflow is flagged instead.

## Interface
Parameters:
- s, 8, number of 17-bit words per operand and result; must match the multiplier.
- FINAL_SUB, 1, 1 = conditional subtraction enabled; 0 = raw result passed through.

Ports:
- clock_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- res_valid_i  in  1  marks res_i as a valid result word this cycle.
- res_i  in  17  result word from the multiplier, LSW first.
- p_i  in  s*17  modulus; word k is p_i[k*17+:17]; held stable from the first word until result_valid_o.
- result_o  out  s*17  reduced result; word k is result_o[k*17+:17].
- result_valid_o  out  1  result_o holds a complete result.
- result_ready_i  in  1  consumer accepts result_o.
- busy_o  out  1  collection in progress (word count 1..s-1).
- overflow_o  out  1  sticky; a word arrived while a result was pending.

## Operation
- States: COLLECT (idx 0..s-1) and DONE.
- COLLECT, on res_valid_i:
  - raw[idx] <= res_i.
  - diff = {1'b0,res_i} − {1'b0,p[idx]} − borrow, computed as 18-bit.
  - sub[idx] <= diff[16:0].
  - borrow <= diff[17].
  - idx <= idx+1.
- borrow is forced to 0 at idx 0: the first word uses borrow-in 0, independent of any previous run.
- On the word with idx = s−1, move to DONE:
  - If FINAL_SUB = 1 and the final borrow-out = 0 (raw ≥ p), result_o <= sub.
  - Otherwise result_o <= raw.
  - Set idx <= 0 and result_valid_o <= 1.
- Equality raw = p gives result 0.
- Raw values ≥ 2p are out of contract; behaviour is a single subtraction only.
- DONE:
  - Hold result_o and result_valid_o until result_valid_o && result_ready_i. Then return to COLLECT and drop result_valid_o on the next cycle.
  - If res_valid_i arrives in the same cycle as the handshake, the word is accepted as idx 0 of the next result.
  - If res_valid_i arrives without the handshake, the word is dropped and overflow_o <= 1. overflow_o is cleared only by reset_i.
- busy_o = (state == COLLECT) && (idx != 0).
- Reset values, effective in the cycle after reset_i is high at an edge:
  - state COLLECT, idx 0, borrow 0.
  - result_valid_o 0, busy_o 0, overflow_o 0, result_o all zeros.
  - raw and sub contents are don't-care.
- Reset in mid-collection discards the partial words. reset_i has priority over res_valid_i in the same cycle.
- p_i is sampled word-by-word as it is used. Changing p_i during collection is out of contract.

## Timing
- Acceptance: one word per cycle at full rate; no gaps are required between words or between results, except that DONE needs the handshake.
- Latency: result_valid_o rises on the edge that captures word s−1, i.e. 1 cycle after that word is presented. result_o is valid in the same cycle as result_valid_o.
- Gaps (res_valid_i low) during collection are tolerated; idx and borrow hold.
- Back-to-back operation: with result_ready_i tied high, result_valid_o is a 1-cycle pulse every s cycles when words are streamed continuously.
- The critical path is one 18-bit subtract plus the borrow register. No combinational path runs from res_i to any output.

## Test plan
- s=2, p = {0,7}, words 9 then 0, ready high → result_valid_o 1 cycle after word 1; result_o = {0,2}.
- s=2, p = {0,7}, words 5,0 → result_o = {0,5}. Words 7,0 → result_o = {0,0}.
- s=2, p = {1,1}, words 0 then 2 (raw 262144) → borrow crosses the word boundary; result_o = {0,0x1FFFF}. The same case with FINAL_SUB=0 → {2,0}.
- Backpressure: hold result_ready_i low for 5 cycles after valid and send 1 word during DONE → result_o unchanged, overflow_o = 1 and stays 1. Then assert ready and stream 2 words → the new result is correct and overflow_o is still 1.
- Handshake collision: assert result_ready_i in the same cycle as the first word of the next result → that word is accepted as idx 0, and the next result is correct.
- Reset after 1 of 2 words → busy_o = 0 and result_valid_o = 0. Then send a fresh 2-word result → it is correct, with no residue from the old word or borrow.
